// File: rtl/addsub_acc.sv
// ---------------------------------------------------------------------------
// addsub_acc
//
// Purpose:
//   This is a registered add/subtract unit with an internal accumulator.
//   Operand beats arrive on a valid/ready handshake. Each accepted beat
//   produces exactly one registered result. That result also leaves on a
//   valid/ready handshake. The output register holds its value while the
//   consumer stalls.
//
//   op = 00 : out = n1 + n2
//   op = 01 : out = n1 - n2
//   op = 10 : acc = acc + n1   (the result goes to both acc and out)
//   op = 11 : acc = acc - n1   (the result goes to both acc and out)
//
//   When clear is set on an accepted beat, the accumulator operand is forced
//   to zero before the op is applied. For ops 00/01, clear zeroes acc.
//
// Parameters:
//   WIDTH    : operand / result / accumulator width in bits (>= 2)
//   SATURATE : 1 = clamp on unsigned carry/borrow, 0 = wrap modulo 2^WIDTH
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   in_valid  in   operand beat present
//   in_ready  out  block can take a beat (!out_valid || out_ready)
//   n1, n2    in   unsigned operands
//   op        in   operation select (see above)
//   clear     in   accumulator clear, sampled only on an accepted beat
//   out_valid out  result present
//   out_ready in   consumer takes the result
//   out       out  registered result
//   carry     out  unsigned carry (add) / borrow (sub) of the raw result
//   ovf       out  two's-complement overflow of the raw result
//   zero      out  out == 0
//   acc       out  current accumulator value
// ---------------------------------------------------------------------------
module addsub_acc #(
  parameter int WIDTH    = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] n1,
  input  logic [WIDTH-1:0] n2,
  input  logic [1:0]       op,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             ovf,
  output logic             zero,
  output logic [WIDTH-1:0] acc
);

  // Decoded operation fields and handshake qualifier.
  logic             accept;
  logic             acc_op;
  logic             is_sub;

  // Datapath operands and the raw (WIDTH+1)-bit result.
  logic [WIDTH-1:0] left;
  logic [WIDTH-1:0] right;
  logic [WIDTH:0]   raw;

  // Flags computed on the raw result, before any saturation.
  logic             raw_carry;
  logic             raw_ovf;

  // Final value after optional saturation, plus its zero flag.
  logic [WIDTH-1:0] result;
  logic             result_zero;

  // The sink side can take a new beat when the output register is empty,
  // or when it is being drained in this same cycle. Draining and loading
  // in the same cycle gives full throughput.
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // The high op bit selects accumulator mode. The low bit selects
  // subtraction in both modes.
  assign acc_op = op[1];
  assign is_sub = op[0];

  // Operand steering. In accumulator mode, the left operand is the
  // accumulator, or zero when clear is set. The right operand is n1 and
  // n2 is unused.
  always_comb begin
    left  = n1;
    right = n2;
    if (acc_op) begin
      left  = clear ? '0 : acc;
      right = n1;
    end
  end

  // The add/sub is done one bit wider than the operands. For an add, the
  // extra bit is the carry out. For a subtract, the zero-extended
  // difference wraps negative exactly when left < right. The top bit then
  // doubles as the borrow.
  always_comb begin
    if (is_sub) begin
      raw = {1'b0, left} - {1'b0, right};
    end else begin
      raw = {1'b0, left} + {1'b0, right};
    end
  end

  assign raw_carry = raw[WIDTH];

  // Signed overflow, read off the sign bits:
  //   add: both operands have the same sign and the result sign differs.
  //   sub: the operands have different signs and the result sign differs
  //        from the left operand.
  always_comb begin
    if (is_sub) begin
      raw_ovf = (left[WIDTH-1] != right[WIDTH-1]) &&
                (raw[WIDTH-1]  != left[WIDTH-1]);
    end else begin
      raw_ovf = (left[WIDTH-1] == right[WIDTH-1]) &&
                (raw[WIDTH-1]  != left[WIDTH-1]);
    end
  end

  // Saturation clamps only on an unsigned carry or borrow. An add clamps
  // to all-ones and a sub clamps to zero. carry and ovf still describe the
  // raw wrapped result, so they bypass this stage.
  always_comb begin
    result = raw[WIDTH-1:0];
    if (SATURATE && raw_carry) begin
      result = is_sub ? '0 : '1;
    end
  end

  assign result_zero = (result == '0);

  // Output valid flag. It is set by any accept. It is cleared only when
  // the consumer drains the result and no new beat replaces it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Result and flag register. All four fields load together on accept.
  // Otherwise they hold. A stalled result therefore cannot change under
  // the consumer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out   <= '0;
      carry <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else if (accept) begin
      out   <= result;
      carry <= raw_carry;
      ovf   <= raw_ovf;
      zero  <= result_zero;
    end
  end

  // Accumulator. It only ever changes on an accepted beat:
  //   - Accumulator ops write back the (possibly saturated) result. Clear
  //     is already folded into the left operand.
  //   - Plain ops leave acc alone unless clear is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (accept) begin
      if (acc_op) begin
        acc <= result;
      end else if (clear) begin
        acc <= '0;
      end
    end
  end

endmodule

// File: tb/tb_addsub_acc.sv
// ---------------------------------------------------------------------------
// tb_addsub_acc
//
// Drives two instances of addsub_acc from the same stimulus. One instance
// wraps and the other saturates. A behavioural model tracks each instance
// using plain integer arithmetic. A compare process checks both instances
// against the model on every falling clock edge. Directed vectors with
// hand-computed values pin the model and the DUT at key points.
// ---------------------------------------------------------------------------
module tb_addsub_acc;

  localparam int W   = 4;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic         clear = 1'b0;
  logic [W-1:0] n1 = '0;
  logic [W-1:0] n2 = '0;
  logic [1:0]   op = 2'b00;

  // Outputs of the wrapping instance.
  logic         w_in_ready, w_out_valid, w_carry, w_ovf, w_zero;
  logic [W-1:0] w_out, w_acc;

  // Outputs of the saturating instance.
  logic         s_in_ready, s_out_valid, s_carry, s_ovf, s_zero;
  logic [W-1:0] s_out, s_acc;

  int checks = 0;
  int passes = 0;
  int xfers  = 0;
  int base;

  // Model state. Index 0 tracks the wrapping instance and index 1 tracks
  // the saturating instance.
  int m_valid[2];
  int m_out[2];
  int m_carry[2];
  int m_ovf[2];
  int m_zero[2];
  int m_acc[2];

  addsub_acc #(.WIDTH(W), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
    .n1(n1), .n2(n2), .op(op), .clear(clear), .out_valid(w_out_valid),
    .out_ready(out_ready), .out(w_out), .carry(w_carry), .ovf(w_ovf),
    .zero(w_zero), .acc(w_acc)
  );

  addsub_acc #(.WIDTH(W), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
    .n1(n1), .n2(n2), .op(op), .clear(clear), .out_valid(s_out_valid),
    .out_ready(out_ready), .out(s_out), .carry(s_carry), .ovf(s_ovf),
    .zero(s_zero), .acc(s_acc)
  );

  always #5 clk = ~clk;

  // Single comparison point. Every check funnels through here.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Drives one beat just after a rising edge. The beat is therefore
  // sampled at the following edge.
  task automatic applyStimulus(input logic v, input int a, input int b,
                               input logic [1:0] o, input logic c, input logic r);
    @(posedge clk);
    #1;
    in_valid  = v;
    n1        = W'(a);
    n2        = W'(b);
    op        = o;
    clear     = c;
    out_ready = r;
  endtask

  // Converts an unsigned W-bit value to its two's-complement integer value.
  function automatic int toSigned(input int v);
    return (v >= MOD / 2) ? v - MOD : v;
  endfunction

  // Advances one model instance by one clock, using plain arithmetic.
  task automatic modelStep(input int k, input int sat);
    int l, r, raw, sres, fin, c, o;
    bit take, sub;
    take = in_valid && (m_valid[k] == 0 || out_ready);
    if (take) begin
      sub = op[0];
      l   = op[1] ? (clear ? 0 : m_acc[k]) : int'(n1);
      r   = op[1] ? int'(n1) : int'(n2);
      raw = sub ? l - r : l + r;
      c   = sub ? int'(l < r) : int'(raw >= MOD);
      sres = sub ? toSigned(l) - toSigned(r) : toSigned(l) + toSigned(r);
      o   = int'(sres >= MOD / 2 || sres < -MOD / 2);
      fin = ((raw % MOD) + MOD) % MOD;
      if (sat != 0 && c != 0) fin = sub ? 0 : MOD - 1;
      m_out[k]   = fin;
      m_carry[k] = c;
      m_ovf[k]   = o;
      m_zero[k]  = int'(fin == 0);
      if (op[1]) m_acc[k] = fin;
      else if (clear) m_acc[k] = 0;
      m_valid[k] = 1;
    end else if (out_ready) begin
      m_valid[k] = 0;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_valid[k] = 0; m_out[k] = 0; m_carry[k] = 0;
        m_ovf[k] = 0; m_zero[k] = 0; m_acc[k] = 0;
      end
    end else begin
      modelStep(0, 0);
      modelStep(1, 1);
    end
  end

  // Counts completed output transfers of the wrapping instance.
  always @(posedge clk) begin
    if (rst_n && w_out_valid && out_ready) xfers++;
  end

  // Checks one instance against the model. The result fields are compared
  // only while a result is present.
  task automatic compareInst(input int k, input string tag, input logic v,
                             input logic rdy, input logic [W-1:0] o,
                             input logic c, input logic ov, input logic z,
                             input logic [W-1:0] a);
    checkOutput({tag, " out_valid"}, int'(v), m_valid[k]);
    checkOutput({tag, " in_ready"}, int'(rdy), int'(m_valid[k] == 0 || out_ready));
    checkOutput({tag, " acc"}, int'(a), m_acc[k]);
    if (m_valid[k] != 0) begin
      checkOutput({tag, " out"}, int'(o), m_out[k]);
      checkOutput({tag, " carry"}, int'(c), m_carry[k]);
      checkOutput({tag, " ovf"}, int'(ov), m_ovf[k]);
      checkOutput({tag, " zero"}, int'(z), m_zero[k]);
    end
  endtask

  always @(negedge clk) begin
    compareInst(0, "wrap", w_out_valid, w_in_ready, w_out, w_carry, w_ovf, w_zero, w_acc);
    compareInst(1, "sat", s_out_valid, s_in_ready, s_out, s_carry, s_ovf, s_zero, s_acc);
  end

  // Extra directed vectors: {valid, n1, n2, op, clear, out_ready}.
  typedef struct {
    logic       v;
    int         a;
    int         b;
    logic [1:0] o;
    logic       c;
    logic       r;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b1, 8, 8, 2'b00, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 0, 1, 2'b01, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 15, 15, 2'b10, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 15, 15, 2'b10, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 4, 2, 2'b11, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 8, 1, 2'b01, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 7, 0, 2'b11, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 0, 0, 2'b00, 1'b0, 1'b1};

    // Reset state, checked while reset is still asserted.
    rst_n = 1'b0;
    #7;
    checkOutput("reset out_valid", int'(w_out_valid), 0);
    checkOutput("reset out", int'(w_out), 0);
    checkOutput("reset acc", int'(w_acc), 0);
    checkOutput("reset zero", int'(w_zero), 0);
    checkOutput("reset in_ready", int'(w_in_ready), 1);
    #5;
    rst_n = 1'b1;

    // op 00: 7 + 1 = 8, with signed overflow.
    applyStimulus(1, 7, 1, 2'b00, 0, 1);
    applyStimulus(0, 0, 0, 2'b00, 0, 1);
    checkOutput("add 7+1 out", int'(w_out), 8);
    checkOutput("add 7+1 carry", int'(w_carry), 0);
    checkOutput("add 7+1 ovf", int'(w_ovf), 1);
    checkOutput("add 7+1 zero", int'(w_zero), 0);
    checkOutput("model 7+1", m_out[0], 8);

    // op 00: 9 + 7 wraps to 0 with a carry.
    applyStimulus(1, 9, 7, 2'b00, 0, 1);
    applyStimulus(0, 0, 0, 2'b00, 0, 1);
    checkOutput("add 9+7 out", int'(w_out), 0);
    checkOutput("add 9+7 carry", int'(w_carry), 1);
    checkOutput("add 9+7 ovf", int'(w_ovf), 0);
    checkOutput("add 9+7 zero", int'(w_zero), 1);

    // op 01: 3 - 5 borrows. It wraps to 14, or saturates to 0.
    applyStimulus(1, 3, 5, 2'b01, 0, 1);
    applyStimulus(0, 0, 0, 2'b00, 0, 1);
    checkOutput("sub 3-5 wrap out", int'(w_out), 14);
    checkOutput("sub 3-5 wrap carry", int'(w_carry), 1);
    checkOutput("sub 3-5 wrap ovf", int'(w_ovf), 0);
    checkOutput("sub 3-5 sat out", int'(s_out), 0);
    checkOutput("sub 3-5 sat carry", int'(s_carry), 1);
    checkOutput("sub 3-5 sat zero", int'(s_zero), 1);
    checkOutput("model sat 3-5", m_out[1], 0);

    // Accumulate 5, 6, 7 back to back. The sequence is 5, 11, 2, with the
    // carry on the last beat.
    applyStimulus(1, 5, 0, 2'b10, 1, 1);
    applyStimulus(1, 6, 0, 2'b10, 0, 1);
    checkOutput("acc beat1 out", int'(w_out), 5);
    checkOutput("acc beat1 acc", int'(w_acc), 5);
    applyStimulus(1, 7, 0, 2'b10, 0, 1);
    checkOutput("acc beat2 out", int'(w_out), 11);
    checkOutput("acc beat2 carry", int'(w_carry), 0);
    applyStimulus(0, 0, 0, 2'b00, 0, 1);
    checkOutput("acc beat3 out", int'(w_out), 2);
    checkOutput("acc beat3 acc", int'(w_acc), 2);
    checkOutput("acc beat3 carry", int'(w_carry), 1);
    checkOutput("acc beat3 sat acc", int'(s_acc), 15);

    // Load acc = 9, then clear together with a subtract of 3. This gives
    // 0 - 3 = 13 with a borrow.
    applyStimulus(1, 9, 0, 2'b10, 1, 1);
    applyStimulus(1, 3, 0, 2'b11, 1, 1);
    checkOutput("preload acc", int'(w_acc), 9);
    applyStimulus(0, 0, 0, 2'b00, 0, 1);
    checkOutput("clear-sub out", int'(w_out), 13);
    checkOutput("clear-sub acc", int'(w_acc), 13);
    checkOutput("clear-sub carry", int'(w_carry), 1);
    checkOutput("clear-sub sat acc", int'(s_acc), 0);

    // Backpressure: the first result holds for three cycles and the
    // second beat waits.
    applyStimulus(1, 2, 3, 2'b00, 0, 0);
    base = xfers;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 4, 4, 2'b00, 0, 0);
      checkOutput("stall out", int'(w_out), 5);
      checkOutput("stall out_valid", int'(w_out_valid), 1);
      checkOutput("stall in_ready", int'(w_in_ready), 0);
    end
    applyStimulus(1, 4, 4, 2'b00, 0, 1);
    checkOutput("stall release out", int'(w_out), 5);
    applyStimulus(0, 0, 0, 2'b00, 0, 1);
    checkOutput("second result out", int'(w_out), 8);
    checkOutput("second result valid", int'(w_out_valid), 1);
    applyStimulus(0, 0, 0, 2'b00, 0, 1);
    applyStimulus(0, 0, 0, 2'b00, 0, 1);
    checkOutput("backpressure transfers", xfers - base, 2);

    // Reset in the middle of a pending result, with acc = 6.
    applyStimulus(1, 6, 0, 2'b10, 1, 0);
    applyStimulus(0, 0, 0, 2'b00, 0, 0);
    checkOutput("pre-reset acc", int'(w_acc), 6);
    checkOutput("pre-reset valid", int'(w_out_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset out_valid", int'(w_out_valid), 0);
    checkOutput("async reset out", int'(w_out), 0);
    checkOutput("async reset acc", int'(w_acc), 0);
    #1;
    rst_n = 1'b1;
    applyStimulus(1, 1, 0, 2'b10, 0, 1);
    applyStimulus(0, 0, 0, 2'b00, 0, 1);
    checkOutput("post-reset acc", int'(w_acc), 1);
    checkOutput("post-reset out", int'(w_out), 1);

    // A clear without an accept must leave acc untouched.
    applyStimulus(0, 0, 0, 2'b00, 1, 1);
    applyStimulus(0, 0, 0, 2'b00, 0, 1);
    checkOutput("idle clear acc", int'(w_acc), 1);

    // The remaining mixed vectors are checked by the model.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].v, vecs[i].a, vecs[i].b, vecs[i].o, vecs[i].c, vecs[i].r);
    end
    repeat (3) applyStimulus(0, 0, 0, 2'b00, 0, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/addsub_acc.md
# addsub_acc

Parametrised, registered add/subtract unit with an internal accumulator, valid/ready handshakes on both sides and status flags. It replaces the purely combinational 4-bit add/subtract selector in the arithmetic exercises. Each accepted operand pair produces one registered result, and the output register holds its value under backpressure. The block sits between an operand source (testbench or sequencer) and any downstream consumer that can stall.

## Interface
- WIDTH, default 4: operand, result and accumulator width in bits (≥2).
- SATURATE, default 0: when 1, results clamp on unsigned carry or borrow; when 0, results wrap modulo 2^WIDTH.

- clk  in  1  sole clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block can accept a beat; combinational: !out_valid || out_ready.
- n1  in  WIDTH  first operand, unsigned.
- n2  in  WIDTH  second operand, unsigned.
- op  in  2  00 out=n1+n2; 01 out=n1-n2; 10 acc=acc+n1; 11 acc=acc-n1.
- clear  in  1  synchronous accumulator clear, sampled only on an accepted beat.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes the result.
- out  out  WIDTH  registered result.
- carry  out  1  unsigned carry (add) or borrow (sub) of the registered result.
- ovf  out  1  two's-complement overflow of the registered result.
- zero  out  1  out == 0.
- acc  out  WIDTH  current accumulator value.

## Operation
- Accept happens when in_valid && in_ready at a rising edge. n1, n2, op and clear are sampled on accept only.
- Op 00/01: computed from n1 and n2 at WIDTH+1 bits. The accumulator is unchanged.
- Op 10/11: left operand is acc, right operand is n1; n2 is ignored. The final result is written to both acc and out.
- Clear on accept:
  - The left accumulator operand becomes 0 before the op is applied. So clear with op 10 gives acc=n1; clear with op 11 gives acc=-n1 mod 2^WIDTH.
  - With op 00/01, clear sets acc=0 and out is the normal n1±n2.
- carry: bit WIDTH of the add sum. For subtraction it means borrow, i.e. left < right unsigned.
- ovf: operands of equal sign giving a result of different sign (add); operands of different sign where the result sign differs from the left operand (sub).
- carry and ovf always describe the raw wrapped result, independent of SATURATE.
- SATURATE=1:
  - An add with carry yields all-ones.
  - A sub with borrow yields 0.
  - The saturated value goes to out, and to acc for ops 10/11.
  - zero is computed on the saturated value.
- Output register: out, carry, ovf and zero load together on accept. They hold stable while out_valid && !out_ready.
- out_valid:
  - set on accept;
  - cleared when out_ready && !accept;
  - stays 1 on simultaneous drain and accept (back-to-back, full throughput).
- No beat is lost or duplicated. Every accept produces exactly one out_valid&&out_ready transfer.

## Timing
- Reset (rst_n low, asynchronous, no clock needed): out_valid=0, out=0, carry=0, ovf=0, zero=0, acc=0. in_ready consequently reads 1 while in reset.
- Reset mid-transaction discards any pending result immediately. The first edge after release may accept.
- Latency: result visible the cycle after accept, i.e. one clock.
- Throughput: one beat per cycle while out_ready is held high.
- Stall: out_valid=1 and out_ready=0 force in_ready=0. Every output holds, and acc does not change.
- A drain and an accept in the same cycle load the new result, and out_valid remains 1.
- clear without an accept has no effect.

## Test plan
- WIDTH=4, op=00:
  - n1=7, n2=1 -> out=8, carry=0, ovf=1, zero=0.
  - then n1=9, n2=7 -> out=0, carry=1, ovf=0, zero=1.
  - both one cycle after accept.
- WIDTH=4, op=01, n1=3, n2=5:
  - SATURATE=0 -> out=14, carry=1, ovf=0.
  - SATURATE=1 -> out=0, carry=1, zero=1.
- Accumulate, SATURATE=0: clear+op10 n1=5, then op10 n1=6, then op10 n1=7 -> out/acc = 5, 11, 2; carry=1 on the third beat only.
- Simultaneous clear and subtract: acc=9, then clear+op11 n1=3 -> out=13, acc=13, carry=1.
- Backpressure:
  - Hold out_ready=0 for 3 cycles and offer two beats (2+3, 4+4).
  - First result out=5 holds for 3 cycles; in_ready=0; the second beat is not accepted.
  - After out_ready=1: 5 transfers, then out=8 next cycle.
  - Exactly two transfers in total.
- Reset mid-operation: with out_valid=1 and acc=6, pulse rst_n low between edges -> out_valid, out and acc read 0 immediately. Next accepted op10 n1=1 -> acc=1.
